// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control FSM: state enum, mux selects,
// memory commands and instruction opcode/op fields.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
    S_WR_IMM, S_GET_A, S_GET_B, S_CALC, S_WR_RD,
    S_CALC_ADDR, S_LD_ADDR, S_MEM_RD1, S_MEM_RD2,
    S_GET_D, S_PASS_D, S_MEM_WR, S_HALT
  } state_t;

  localparam logic [3:0] VSEL_NONE  = 4'b0000;
  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM   = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Moore controller sequencing fetch, decode and execute micro-steps of the
// 16-bit CPU; one datapath/memory micro-step per clock.
module cpu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] ALUop,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  state_t r_state;
  state_t w_next;
  logic   w_is_mov_reg;
  logic   w_is_cmp;

  // IR is held from UPD_PC to the next IF2, so these decodes are stable per state.
  assign w_is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign w_is_cmp     = (opcode == OPC_ALU) && (op == ALU_CMP);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:    w_next = S_IF1;
      S_IF1:    w_next = S_IF2;
      S_IF2:    w_next = S_UPD_PC;
      S_UPD_PC: w_next = S_DECODE;
      S_DECODE: begin
        casez ({opcode, op})
          {OPC_MOV, OP_MOV_IMM}: w_next = S_WR_IMM;
          {OPC_MOV, OP_MOV_REG}: w_next = S_GET_B;
          {OPC_ALU, 2'b??}:      w_next = S_GET_A;
          {OPC_LDR, 2'b00}:      w_next = S_GET_A;
          {OPC_STR, 2'b00}:      w_next = S_GET_A;
          default:               w_next = S_HALT;
        endcase
      end
      S_WR_IMM:    w_next = S_IF1;
      S_GET_A:     w_next = (opcode == OPC_ALU) ? S_GET_B : S_CALC_ADDR;
      S_GET_B:     w_next = S_CALC;
      S_CALC:      w_next = w_is_cmp ? S_IF1 : S_WR_RD;
      S_WR_RD:     w_next = S_IF1;
      S_CALC_ADDR: w_next = S_LD_ADDR;
      S_LD_ADDR:   w_next = (opcode == OPC_LDR) ? S_MEM_RD1 : S_GET_D;
      S_MEM_RD1:   w_next = S_MEM_RD2;
      S_MEM_RD2:   w_next = S_IF1;
      S_GET_D:     w_next = S_PASS_D;
      S_PASS_D:    w_next = S_MEM_WR;
      S_MEM_WR:    w_next = S_IF1;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_RST;
    endcase
  end

  always_comb begin
    nsel      = NSEL_NONE;
    vsel      = VSEL_NONE;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    ALUop     = ALU_ADD;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (r_state)
      S_RST:    begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:    begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:    begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPD_PC: load_pc = 1'b1;
      S_WR_IMM: begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
      S_GET_A:  begin nsel = NSEL_RN; loada = 1'b1; end
      S_GET_B:  begin nsel = NSEL_RM; loadb = 1'b1; end
      S_CALC: begin
        // MOV reg passes Rm through as 0 + B.
        asel  = w_is_mov_reg;
        ALUop = w_is_mov_reg ? ALU_ADD : op;
        loadc = 1'b1;
        loads = w_is_cmp;
      end
      S_WR_RD:     begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_CALC_ADDR: begin bsel = 1'b1; loadc = 1'b1; end
      S_LD_ADDR:   load_addr = 1'b1;
      S_MEM_RD1:   mem_cmd = MEM_READ;
      S_MEM_RD2: begin
        mem_cmd = MEM_READ;
        nsel    = NSEL_RD;
        vsel    = VSEL_MDATA;
        write   = 1'b1;
      end
      S_GET_D:  begin nsel = NSEL_RD; loadb = 1'b1; end
      S_PASS_D: begin asel = 1'b1; loadc = 1'b1; end
      S_MEM_WR: mem_cmd = MEM_WRITE;
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus schedules expected output
// vectors by cycle; a negedge monitor pops and compares them.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write;
  logic [1:0] ALUop, mem_cmd;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .ALUop(ALUop), .write(write), .load_ir(load_ir), .load_pc(load_pc),
    .reset_pc(reset_pc), .load_addr(load_addr), .addr_sel(addr_sel),
    .mem_cmd(mem_cmd), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum {
    E_RST, E_IF1, E_IF2, E_UPD, E_DEC, E_WR_IMM, E_GET_A, E_GET_B, E_CALC,
    E_WR_RD, E_CALC_ADDR, E_LD_ADDR, E_MEM_RD1, E_MEM_RD2, E_GET_D,
    E_PASS_D, E_MEM_WR, E_HALT
  } est_e;

  typedef struct {
    int          tag;
    est_e        st;
    logic [23:0] v;
  } exp_t;

  exp_t q[$];
  int   pcnt = 0;
  int   etag = 0;
  int   ncmp = 0;
  int   nerr = 0;

  logic [23:0] got;
  assign got = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop,
                write, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                mem_cmd, halted};

  // Expected outputs per step, written straight from the state table.
  function automatic logic [23:0] model(est_e s, logic [2:0] opc, logic [1:0] o);
    logic [2:0] ns; logic [3:0] vs; logic [1:0] alu, mc;
    logic la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, lad, ads, hl;
    ns = 3'b000; vs = 4'b0000; alu = 2'b00; mc = 2'b00;
    la = 0; lb = 0; lc = 0; ls = 0; as = 0; bs = 0; wr = 0;
    lir = 0; lpc = 0; rpc = 0; lad = 0; ads = 0; hl = 0;
    case (s)
      E_RST:       begin rpc = 1; lpc = 1; end
      E_IF1:       begin ads = 1; mc = 2'b01; end
      E_IF2:       begin ads = 1; mc = 2'b01; lir = 1; end
      E_UPD:       lpc = 1;
      E_WR_IMM:    begin ns = 3'b001; vs = 4'b0100; wr = 1; end
      E_GET_A:     begin ns = 3'b001; la = 1; end
      E_GET_B:     begin ns = 3'b100; lb = 1; end
      E_CALC: begin
        as  = (opc == 3'b110);
        alu = (opc == 3'b110) ? 2'b00 : o;
        lc  = 1;
        ls  = (opc == 3'b101) && (o == 2'b01);
      end
      E_WR_RD:     begin ns = 3'b010; vs = 4'b0001; wr = 1; end
      E_CALC_ADDR: begin bs = 1; lc = 1; end
      E_LD_ADDR:   lad = 1;
      E_MEM_RD1:   mc = 2'b01;
      E_MEM_RD2:   begin mc = 2'b01; ns = 3'b010; vs = 4'b1000; wr = 1; end
      E_GET_D:     begin ns = 3'b010; lb = 1; end
      E_PASS_D:    begin as = 1; lc = 1; end
      E_MEM_WR:    mc = 2'b10;
      E_HALT:      hl = 1;
      default:     ;
    endcase
    return {ns, vs, la, lb, lc, ls, as, bs, alu, wr, lir, lpc, rpc, lad, ads, mc, hl};
  endfunction

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic push(input est_e s);
    exp_t e;
    etag++;
    e.tag = etag;
    e.st  = s;
    e.v   = model(s, opcode, op);
    q.push_back(e);
  endtask

  task automatic sync();
    while (pcnt < etag) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
    push(E_IF2);
    push(E_UPD);
    push(E_DEC);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push(E_RST);
    sync();
    reset = 1'b0;
    push(E_IF1);
    sync();
  endtask

  // Monitor: every negedge is one presented output cycle.
  initial begin
    int nidx;
    exp_t e;
    nidx = 0;
    forever begin
      @(negedge clk);
      nidx++;
      while (q.size() > 0 && q[0].tag <= nidx) begin
        e = q.pop_front();
        ncmp++;
        if (e.tag != nidx || got !== e.v) begin
          nerr++;
          $display("FAIL %s cycle %0d (sched %0d): got %h expected %h",
                   e.st.name(), nidx, e.tag, got, e.v);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, %0d pending", q.size());
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = 3'b000; op = 2'b00;
    push(E_RST); push(E_RST);
    sync();
    reset = 1'b0;
    push(E_IF1);
    sync();

    // MOV imm: 5 cycles IF1..IF1
    fetch(3'b110, 2'b10); push(E_WR_IMM); push(E_IF1); sync();
    // MOV reg: 7
    fetch(3'b110, 2'b00); push(E_GET_B); push(E_CALC); push(E_WR_RD); push(E_IF1); sync();
    // ADD, AND, MVN: 8
    for (int k = 0; k < 3; k++) begin
      logic [1:0] o;
      o = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
      fetch(3'b101, o);
      push(E_GET_A); push(E_GET_B); push(E_CALC); push(E_WR_RD); push(E_IF1);
      sync();
    end
    // CMP: 7, no writeback
    fetch(3'b101, 2'b01); push(E_GET_A); push(E_GET_B); push(E_CALC); push(E_IF1); sync();
    // LDR: 9
    fetch(3'b011, 2'b00);
    push(E_GET_A); push(E_CALC_ADDR); push(E_LD_ADDR); push(E_MEM_RD1); push(E_MEM_RD2);
    push(E_IF1); sync();
    // STR: 10
    fetch(3'b100, 2'b00);
    push(E_GET_A); push(E_CALC_ADDR); push(E_LD_ADDR); push(E_GET_D); push(E_PASS_D);
    push(E_MEM_WR); push(E_IF1); sync();
    // HALT holds until reset
    fetch(3'b111, 2'b00);
    repeat (20) push(E_HALT);
    sync();
    do_reset();
    // illegal code also halts
    fetch(3'b000, 2'b00);
    repeat (20) push(E_HALT);
    sync();
    do_reset();
    // STR aborted at LD_ADDR: no write command may follow
    fetch(3'b100, 2'b00);
    push(E_GET_A); push(E_CALC_ADDR); push(E_LD_ADDR);
    sync();
    do_reset();
    // recovery after abort
    fetch(3'b110, 2'b10); push(E_WR_IMM); push(E_IF1); sync();

    @(negedge clk);
    @(negedge clk);
    #1;
    ncmp++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Moore state machine that sequences the 16-bit register/ALU datapath, plus the fetch path (PC, instruction register, data-address register, memory command).
- Takes decoded opcode/op fields from the instruction decoder.
- Drives every datapath control strobe, the register-select code (nsel) and the memory interface, one micro-step per clock.
- Sits between the instruction register/decoder and the datapath inside the CPU top level.

Parameters:
- none. All encodings are constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; forces state RST on the next edge
- opcode  in  3  instruction bits [15:13] from the decoder
- op  in  2  instruction bits [12:11] from the decoder
- nsel  out  3  one-hot register select to the decoder: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  out  4  writeback mux select: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
- loada, loadb, loadc, loads  out  1 each  datapath register/status enables
- asel, bsel  out  1 each  ALU operand selects (asel=1 gives A=0; bsel=1 gives B=sximm5)
- ALUop  out  2  ALU operation
- write  out  1  register file write enable
- load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1 each  fetch-path controls (addr_sel=1 selects PC as memory address)
- mem_cmd  out  2  MEM_NONE 00, MEM_READ 01, MEM_WRITE 10
- halted  out  1  high in HALT

Behaviour:
- All outputs are a pure function of the state register. Every output is 0 (vsel 0000) unless it is listed for the current state.
- On a reset edge, state becomes RST, whatever state it was in, including mid-instruction or HALT. A partially executed instruction is abandoned with no further writes.
- RST: reset_pc=1, load_pc=1. Go to IF1.
- IF1: addr_sel=1, mem_cmd=READ. Go to IF2.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1. Go to UPD_PC.
- UPD_PC: load_pc=1. Go to DECODE.
- DECODE: no strobes. Dispatch on {opcode,op}:
  - 110_10 MOV imm: go to WR_IMM.
  - 110_00 MOV reg: go to GET_B.
  - 101_xx ALU: go to GET_A.
  - 011_00 LDR: go to GET_A.
  - 100_00 STR: go to GET_A.
  - 111_00 HALT, or any other code: go to HALT.
- WR_IMM: nsel=Rn, vsel=0100, write=1. Go to IF1.
- GET_A: nsel=Rn, loada=1. ALU goes to GET_B; LDR/STR go to CALC_ADDR.
- GET_B: nsel=Rm, loadb=1. Go to CALC.
- CALC: asel=1 for MOV reg, else 0; bsel=0; ALUop=00 for MOV reg, else op; loadc=1; loads=1 only for CMP (101_01). CMP goes to IF1; all others go to WR_RD.
- WR_RD: nsel=Rd, vsel=0001, write=1. Go to IF1.
- CALC_ADDR: asel=0, bsel=1, ALUop=00, loadc=1. Go to LD_ADDR.
- LD_ADDR: load_addr=1. LDR goes to MEM_RD1; STR goes to GET_D.
- MEM_RD1: addr_sel=0, mem_cmd=READ. Go to MEM_RD2.
- MEM_RD2: mem_cmd=READ, nsel=Rd, vsel=1000, write=1. Go to IF1.
- GET_D: nsel=Rd, loadb=1. Go to PASS_D.
- PASS_D: asel=1, bsel=0, ALUop=00, loadc=1. Go to MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=WRITE. Go to IF1.
- HALT: halted=1. Stays in HALT until reset.
- Latency in cycles from IF1 back to IF1:
  - MOV imm 5; MOV reg 7; ADD/AND/MVN 8; CMP 7; LDR 9; STR 10.
- opcode/op are sampled only in DECODE and in branch states. They must remain stable (IR held) from UPD_PC until the next IF2.

Decomposition:
- Package cpu_pkg holds:
  - state enum state_t
  - vsel constants VSEL_C/PC/IMM/MDATA
  - NSEL_RN/RD/RM
  - MEM_NONE/READ/WRITE
  - opcode constants OPC_MOV/ALU/LDR/STR/HALT
  - ALU op constants
- Single module: next-state always_comb, output always_comb, one state always_ff. No sub-module.

Test Plan:
- reset high 2 cycles, then low -> RST then IF1. The RST cycle shows reset_pc=1, load_pc=1; IF2 shows load_ir=1; UPD_PC shows load_pc=1.
- MOV imm (110_10) at DECODE -> next cycle nsel=001, vsel=0100, write=1; next cycle is IF1 with mem_cmd=01, addr_sel=1.
- CMP (101_01) -> GET_A loada, GET_B loadb, CALC with ALUop=01, loadc=1, loads=1. write never asserts; back to IF1 after 7 cycles.
- STR (100_00) -> sequence GET_A, CALC_ADDR (bsel=1), LD_ADDR, GET_D (nsel=010), PASS_D (asel=1), MEM_WR (mem_cmd=10, addr_sel=0), IF1.
- LDR (011_00) -> MEM_RD2 asserts vsel=1000, nsel=010, write=1 with mem_cmd=01; then IF1.
- HALT (111_00), and illegal 000_00 -> halted=1 held for 20 cycles. reset asserted in HALT, or mid-STR at LD_ADDR -> RST on the next edge with no mem_cmd=10 issued.
